// File: rtl/sensor_conditioner_pkg.sv
// Shared channel indices and counter sizing for the sensor conditioner.
// Optional build macro: SENSOR_CONDITIONER_BF_LATCH_EN (used by the top).
package sensor_conditioner_pkg;

  localparam int CH_IDX = 0;
  localparam int BF_IDX = 1;
  localparam int SF_IDX = 2;
  localparam int SD_IDX = 3;
  localparam int SE_IDX = 4;
  localparam int ST_IDX = 5;
  localparam int NUM_CH = 6;

  // Bits needed to count 0..n-1, never less than one bit.
  function automatic int deb_cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sensor_conditioner_debounce_bit.sv
// One conditioned channel: synchroniser chain, tick-driven debounce counter
// and the debounced level register. Exposes the next level for the top.
module debounce_bit
  import sensor_conditioner_pkg::*;
#(
  parameter int DEB_CYCLES  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic tick_i,
  input  logic raw_i,
  output logic level_nxt_o
);

  localparam int CW = deb_cnt_w(DEB_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   sample;

  assign sample      = sync_q[SYNC_STAGES-1];
  assign level_nxt_o = level_d;

  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (tick_i) begin
      if (sample == level_q) begin
        cnt_d = '0;
      end else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
        level_d = ~level_q;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], raw_i};
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

endmodule

// File: rtl/sensor_conditioner.sv
// Robot sensor front-end: sync + debounce of six raw inputs, READY and EVT.
// Build macro SENSOR_CONDITIONER_BF_LATCH_EN holds BF high until CH drops.
module sensor_conditioner
  import sensor_conditioner_pkg::*;
#(
  parameter int TICK_DIV    = 1000,
  parameter int DEB_CYCLES  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic CH_RAW,
  input  logic BF_RAW,
  input  logic SF_RAW,
  input  logic SD_RAW,
  input  logic SE_RAW,
  input  logic ST_RAW,
  output logic CH,
  output logic BF,
  output logic SF,
  output logic SD,
  output logic SE,
  output logic ST,
  output logic READY,
  output logic EVT
);

  localparam int PW = deb_cnt_w(TICK_DIV);
  localparam int RW = deb_cnt_w(DEB_CYCLES);

  logic [PW-1:0]     presc_q, presc_d;
  logic              tick;
  logic [RW-1:0]     rdy_cnt_q, rdy_cnt_d;
  logic              ready_q, ready_d;
  logic [NUM_CH-1:0] raw, lvl_d, out_q, out_d;
  logic              evt_q, evt_d;

  assign raw[CH_IDX] = CH_RAW;
  assign raw[BF_IDX] = BF_RAW;
  assign raw[SF_IDX] = SF_RAW;
  assign raw[SD_IDX] = SD_RAW;
  assign raw[SE_IDX] = SE_RAW;
  assign raw[ST_IDX] = ST_RAW;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_deb
    debounce_bit #(
      .DEB_CYCLES (DEB_CYCLES),
      .SYNC_STAGES(SYNC_STAGES)
    ) u_deb (
      .clk_i      (CLK),
      .rst_ni     (RST_N),
      .tick_i     (tick),
      .raw_i      (raw[i]),
      .level_nxt_o(lvl_d[i])
    );
  end

  always_comb begin
    tick    = (presc_q == PW'(TICK_DIV - 1));
    presc_d = tick ? '0 : presc_q + 1'b1;
  end

  always_comb begin
    rdy_cnt_d = rdy_cnt_q;
    ready_d   = ready_q;
    if (tick && !ready_q) begin
      if (rdy_cnt_q == RW'(DEB_CYCLES - 1)) begin
        ready_d = 1'b1;
      end else begin
        rdy_cnt_d = rdy_cnt_q + 1'b1;
      end
    end
  end

  // Outputs are computed from next-state values so EVT lines up with them.
  always_comb begin
    out_d         = lvl_d;
    out_d[CH_IDX] = lvl_d[CH_IDX] & ready_d;
`ifdef SENSOR_CONDITIONER_BF_LATCH_EN
    out_d[BF_IDX] = lvl_d[BF_IDX] | (out_q[BF_IDX] & out_d[CH_IDX]);
`else
    out_d[BF_IDX] = lvl_d[BF_IDX];
`endif
    evt_d = (out_d != out_q);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      presc_q   <= '0;
      rdy_cnt_q <= '0;
      ready_q   <= 1'b0;
      out_q     <= '0;
      evt_q     <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      rdy_cnt_q <= rdy_cnt_d;
      ready_q   <= ready_d;
      out_q     <= out_d;
      evt_q     <= evt_d;
    end
  end

  assign CH    = out_q[CH_IDX];
  assign BF    = out_q[BF_IDX];
  assign SF    = out_q[SF_IDX];
  assign SD    = out_q[SD_IDX];
  assign SE    = out_q[SE_IDX];
  assign ST    = out_q[ST_IDX];
  assign READY = ready_q;
  assign EVT   = evt_q;

endmodule

// File: tb/tb_sensor_conditioner.sv
// Bench for sensor_conditioner with TICK_DIV=4, DEB_CYCLES=4, SYNC_STAGES=2.
// Output vectors are packed {ST,SE,SD,SF,BF,CH}.
module tb_sensor_conditioner;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  logic CH_RAW = 1'b1, BF_RAW = 1'b1, SF_RAW = 1'b1;
  logic SD_RAW = 1'b1, SE_RAW = 1'b1, ST_RAW = 1'b1;
  logic CH, BF, SF, SD, SE, ST, READY, EVT;
  logic [5:0] outs;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [5:0] exp_q[$];
  logic [5:0] prev_outs = '0;

  typedef struct {
    logic [5:0] raw;
    int         hold;
    logic [5:0] exp;
    bit         chg;
    bit         chk;
  } vec_t;

  vec_t tbl[11];

  sensor_conditioner #(
    .TICK_DIV   (4),
    .DEB_CYCLES (4),
    .SYNC_STAGES(2)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .CH_RAW(CH_RAW),
    .BF_RAW(BF_RAW),
    .SF_RAW(SF_RAW),
    .SD_RAW(SD_RAW),
    .SE_RAW(SE_RAW),
    .ST_RAW(ST_RAW),
    .CH    (CH),
    .BF    (BF),
    .SF    (SF),
    .SD    (SD),
    .SE    (SE),
    .ST    (ST),
    .READY (READY),
    .EVT   (EVT)
  );

  assign outs = {ST, SE, SD, SF, BF, CH};

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_raw(input logic [5:0] v);
    {ST_RAW, SE_RAW, SD_RAW, SF_RAW, BF_RAW, CH_RAW} = v;
  endtask

  // Edges since reset release; ticks are consumed on edges where cyc%4==0.
  initial forever begin
    @(posedge CLK);
    if (RST_N) cyc++;
    else cyc = 0;
  end

  // Scoreboard: every output change must coincide with EVT and match the queue head.
  initial begin
    logic [5:0] e;
    forever begin
      @(negedge CLK);
      if (RST_N !== 1'b1) begin
        prev_outs = outs;
      end else begin
        if (EVT === 1'b1 || outs !== prev_outs) begin
          check("evt_on_change", 32'(EVT), 32'(outs !== prev_outs));
          if (EVT === 1'b1) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL evt_unexpected: got outs %0h with EVT, expected no event", outs);
            end else begin
              e = exp_q.pop_front();
              check("evt_outs", 32'(outs), 32'(e));
            end
          end
        end
        prev_outs = outs;
      end
    end
  end

  initial begin
    int lat;
    tbl[0]  = '{6'h3B, 24, 6'h3B, 1'b1, 1'b1};  // SF falls
    tbl[1]  = '{6'h2B, 24, 6'h2B, 1'b1, 1'b1};  // SE falls
    tbl[2]  = '{6'h3B, 12, 6'h2B, 1'b0, 1'b1};  // SE glitch of 3 ticks
    tbl[3]  = '{6'h2B, 24, 6'h2B, 1'b0, 1'b1};
    tbl[4]  = '{6'h3B, 24, 6'h3B, 1'b1, 1'b1};  // SE held high, rises
    tbl[5]  = '{6'h13, 24, 6'h13, 1'b1, 1'b1};  // SD and ST together
    tbl[6]  = '{6'h39, 24, 6'h39, 1'b1, 1'b1};  // SD, ST, BF together
    tbl[7]  = '{6'h3B, 16, 6'h3B, 1'b1, 1'b0};  // BF pulse of 4 ticks
`ifdef SENSOR_CONDITIONER_BF_LATCH_EN
    tbl[8]  = '{6'h39, 24, 6'h3B, 1'b0, 1'b1};  // BF latched while CH=1
`else
    tbl[8]  = '{6'h39, 24, 6'h39, 1'b1, 1'b1};  // BF follows BF_RAW down
`endif
    tbl[9]  = '{6'h38, 24, 6'h38, 1'b1, 1'b1};  // CH off
    tbl[10] = '{6'h39, 24, 6'h39, 1'b1, 1'b1};  // CH back on

    // Reset with all raw inputs high
    RST_N = 1'b0;
    set_raw(6'h3F);
    repeat (3) @(negedge CLK);
    check("rst_outs", 32'(outs), 32'h0);
    check("rst_ready", 32'(READY), 32'h0);
    check("rst_evt", 32'(EVT), 32'h0);
    #1 RST_N = 1'b1;
    exp_q.push_back(6'h3F);
    for (int i = 1; i <= 16; i++) begin
      @(negedge CLK);
      if (i == 15) begin
        check("ready_c15", 32'(READY), 32'h0);
        check("outs_c15", 32'(outs), 32'h0);
      end
      if (i == 16) begin
        check("ready_c16", 32'(READY), 32'h1);
        check("outs_c16", 32'(outs), 32'h3F);
        check("evt_c16", 32'(EVT), 32'h1);
      end
    end
    @(negedge CLK);
    check("evt_c17", 32'(EVT), 32'h0);

    for (int i = 0; i < 11; i++) begin
      @(negedge CLK);
      #1 set_raw(tbl[i].raw);
      if (tbl[i].chg) exp_q.push_back(tbl[i].exp);
      repeat (tbl[i].hold - 1) @(negedge CLK);
      if (tbl[i].chk) check($sformatf("tbl%0d_outs", i), 32'(outs), 32'(tbl[i].exp));
    end

    // Clean SF edge at a random tick phase
    repeat ($urandom_range(0, 3)) @(negedge CLK);
    @(negedge CLK);
    #1 set_raw(6'h3D);
    exp_q.push_back(6'h3D);
    lat = 0;
    while (SF !== 1'b1 && lat < 30) begin
      @(negedge CLK);
      lat++;
    end
    check("sf_latency_min", 32'(lat >= 15), 32'h1);
    check("sf_latency_max", 32'(lat <= 19), 32'h1);
    check("sf_evt", 32'(EVT), 32'h1);
    check("sf_ready", 32'(READY), 32'h1);

    // Async reset while SF's counter holds 2
    lat = 0;
    do begin
      @(negedge CLK);
      lat++;
    end while (cyc % 4 != 0 && lat < 8);
    #1 set_raw(6'h39);
    repeat (8) @(negedge CLK);
    #1 RST_N = 1'b0;
    #1;
    check("async_outs", 32'(outs), 32'h0);
    check("async_ready", 32'(READY), 32'h0);
    check("async_evt", 32'(EVT), 32'h0);
    repeat (2) @(negedge CLK);
    #1 RST_N = 1'b1;
    exp_q.push_back(6'h39);
    for (int i = 1; i <= 16; i++) begin
      @(negedge CLK);
      if (i == 15) begin
        check("rerun_outs_c15", 32'(outs), 32'h0);
        check("rerun_ready_c15", 32'(READY), 32'h0);
      end
      if (i == 16) begin
        check("rerun_outs_c16", 32'(outs), 32'h39);
        check("rerun_ready_c16", 32'(READY), 32'h1);
      end
    end
    repeat (4) @(negedge CLK);
    check("queue_empty", 32'(exp_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
